// File: rtl/con3_servo_ctrl.sv
// -----------------------------------------------------------------------------
// con3_servo_ctrl
//
// Byte-protocol command parser sitting between a UART transceiver and a Pmod
// CON3 servo driver. Frames are a header byte (sync nibble 4'hA, op bit,
// channel) optionally followed by NB = ceil(ANGLE_W/8) data bytes, MSB first.
// Writes update a per-channel angle register and are answered with ACK 0x06.
// Reads are answered with NB readback bytes. Malformed headers are answered
// with NAK 0x15. Stalled frames are discarded silently after TIMEOUT_CYC
// cycles.
//
// Optional feature macro: CON3_SLEW_EN
//   When it is defined, every channel ramps its output one LSB per SLEW_DIV
//   cycles toward the written target. When it is undefined, a write lands on
//   the output at once.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   rx_data    received byte, valid while rx_valid = 1
//   rx_valid   one-cycle strobe per received byte
//   tx_ready   transmitter idle
//   tx_data    byte to transmit, held stable while it is sent
//   tx_send    one-cycle transmit request
//   angle      channel k at bits [k*ANGLE_W +: ANGLE_W]
//   busy       frame in progress or response pending
//   frame_err  one-cycle pulse on any protocol error
// -----------------------------------------------------------------------------
module con3_servo_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int ANGLE_W     = 8,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int SLEW_DIV    = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  input  logic                         tx_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_send,
  output logic [CHANNELS*ANGLE_W-1:0]  angle,
  output logic                         busy,
  output logic                         frame_err
);

  localparam int         NB  = (ANGLE_W + 7) / 8;  // data bytes per value
  localparam int         QW  = NB * 8;             // response/data shift width
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Parameter sanity checks, evaluated at elaboration only.
  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("con3_servo_ctrl: CHANNELS must be 1..8");
  end
  if (ANGLE_W < 1 || ANGLE_W > 16) begin : g_bad_angle_w
    $error("con3_servo_ctrl: ANGLE_W must be 1..16");
  end
  if (TIMEOUT_CYC < 1 || SLEW_DIV < 1) begin : g_bad_timing
    $error("con3_servo_ctrl: TIMEOUT_CYC and SLEW_DIV must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_COMMIT,
    S_RESP,
    S_WAIT_TX
  } state_t;

  state_t               state_q;
  logic [2:0]           chan_q;       // channel addressed by the current write
  logic [1:0]           byte_cnt_q;   // data bytes received so far
  logic [QW-1:0]        data_q;       // assembled write value
  logic [31:0]          tmo_q;        // inter-byte timeout counter
  logic [QW-1:0]        resp_q;       // response queue, next byte at the top
  logic [1:0]           resp_left_q;  // bytes still to send
  logic                 seen_low_q;   // tx_ready has dropped since tx_send
  logic [7:0]           tx_data_q;
  logic                 tx_send_q;
  logic                 frame_err_q;
  logic [ANGLE_W-1:0]   target_q [CHANNELS];

  logic                 hdr_ok;
  logic                 tmo_hit;
  logic [ANGLE_W-1:0]   rd_sel;

  // Header is usable only with the right sync nibble and an existing channel.
  assign hdr_ok  = (rx_data[7:4] == 4'hA) && (int'(rx_data[2:0]) < CHANNELS);
  // True on the cycle the counter steps onto TIMEOUT_CYC-1.
  assign tmo_hit = (tmo_q + 32'd1) >= (32'(TIMEOUT_CYC) - 32'd1);

  // Readback mux: target of the channel named by the incoming header.
  // NOTE: a combinational block assigns a default first so every path
  // drives the output and no latch is inferred.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (rx_data[2:0] == 3'(k)) rd_sel = target_q[k];
    end
  end

  // Places a single byte at the head of the response queue.
  function automatic logic [QW-1:0] head_byte(input logic [7:0] b);
    logic [QW-1:0] w;
    w = '0;
    w[QW-1 -: 8] = b;
    return w;
  endfunction

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chan_q      <= '0;
      byte_cnt_q  <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      resp_q      <= '0;
      resp_left_q <= '0;
      seen_low_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_send_q   <= 1'b0;
      frame_err_q <= 1'b0;
      // NOTE: the angle registers are few and drive servos directly, so they
      // are reset like ordinary flops rather than left as unreset storage.
      for (int k = 0; k < CHANNELS; k++) target_q[k] <= '0;
    end else begin
      tx_send_q   <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            tmo_q <= '0;
            if (!hdr_ok) begin
              frame_err_q <= 1'b1;
              resp_q      <= head_byte(NAK);
              resp_left_q <= 2'd1;
              state_q     <= S_RESP;
            end else if (!rx_data[3]) begin
              chan_q     <= rx_data[2:0];
              byte_cnt_q <= '0;
              data_q     <= '0;
              state_q    <= S_DATA;
            end else begin
              resp_q      <= QW'(rd_sel);  // upper pad bits are zero
              resp_left_q <= 2'(NB);
              state_q     <= S_RESP;
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            tmo_q  <= '0;
            data_q <= (data_q << 8) | QW'(rx_data);
            if (byte_cnt_q == 2'(NB - 1)) state_q <= S_COMMIT;
            else byte_cnt_q <= byte_cnt_q + 2'd1;
          end else if (tmo_hit) begin
            // Stalled frame: drop it quietly, registers untouched.
            frame_err_q <= 1'b1;
            tmo_q       <= '0;
            state_q     <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end

        S_COMMIT: begin
          // Only the low ANGLE_W bits of the assembled word are kept.
          for (int k = 0; k < CHANNELS; k++) begin
            if (chan_q == 3'(k)) target_q[k] <= data_q[ANGLE_W-1:0];
          end
          resp_q      <= head_byte(ACK);
          resp_left_q <= 2'd1;
          state_q     <= S_RESP;
        end

        S_RESP: begin
          if (tx_ready) begin
            tx_data_q   <= resp_q[QW-1 -: 8];
            tx_send_q   <= 1'b1;
            resp_q      <= resp_q << 8;
            resp_left_q <= resp_left_q - 2'd1;
            seen_low_q  <= 1'b0;
            state_q     <= S_WAIT_TX;
          end
        end

        S_WAIT_TX: begin
          // The byte is done once tx_ready has gone low and come back high.
          if (!tx_ready) begin
            seen_low_q <= 1'b1;
          end else if (seen_low_q) begin
            state_q <= (resp_left_q != 2'd0) ? S_RESP : S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase

      // Bytes arriving while a response is owed are dropped as overruns.
      if (rx_valid && (state_q == S_COMMIT || state_q == S_RESP ||
                       state_q == S_WAIT_TX)) begin
        frame_err_q <= 1'b1;
      end
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);

`ifdef CON3_SLEW_EN
  // Shared prescaler; each wrap moves every lagging channel one LSB.
  logic [31:0]        presc_q;
  logic [ANGLE_W-1:0] cur_q [CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      for (int k = 0; k < CHANNELS; k++) cur_q[k] <= '0;
    end else if (presc_q == 32'(SLEW_DIV - 1)) begin
      presc_q <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        if (cur_q[k] < target_q[k])      cur_q[k] <= cur_q[k] + 1'b1;
        else if (cur_q[k] > target_q[k]) cur_q[k] <= cur_q[k] - 1'b1;
      end
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_angle
    assign angle[g*ANGLE_W +: ANGLE_W] = cur_q[g];
  end
`else
  for (genvar g = 0; g < CHANNELS; g++) begin : g_angle
    assign angle[g*ANGLE_W +: ANGLE_W] = target_q[g];
  end
`endif

endmodule

// File: tb/tb_con3_servo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_con3_servo_ctrl
//
// Two instances: dut0 (4 channels, 8-bit angles) and dut1 (4 channels, 12-bit
// angles), both with a 50-cycle frame timeout. A transmitter model answers
// tx_send by dropping tx_ready for a few cycles; every transmitted byte is
// compared against a queue of expected bytes pushed when the frame is driven.
// A table of frames covers writes, reads, NAKs and overruns; hand-written
// sequences cover timeout, commit latency and (with CON3_SLEW_EN) ramping.
// -----------------------------------------------------------------------------
module tb_con3_servo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  rx_data0 = '0, rx_data1 = '0;
  logic        rx_valid0 = 1'b0, rx_valid1 = 1'b0;
  logic        tx_ready0 = 1'b1, tx_ready1 = 1'b1;
  logic [7:0]  tx_data0, tx_data1;
  logic        tx_send0, tx_send1;
  logic [31:0] angle0;
  logic [47:0] angle1;
  logic        busy0, busy1, frame_err0, frame_err1;

  con3_servo_ctrl #(.CHANNELS(4), .ANGLE_W(8), .TIMEOUT_CYC(50), .SLEW_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data0), .rx_valid(rx_valid0),
    .tx_ready(tx_ready0), .tx_data(tx_data0), .tx_send(tx_send0),
    .angle(angle0), .busy(busy0), .frame_err(frame_err0));

  con3_servo_ctrl #(.CHANNELS(4), .ANGLE_W(12), .TIMEOUT_CYC(50), .SLEW_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .rx_data(rx_data1), .rx_valid(rx_valid1),
    .tx_ready(tx_ready1), .tx_data(tx_data1), .tx_send(tx_send1),
    .angle(angle1), .busy(busy1), .frame_err(frame_err1));

  int checks = 0;
  int errors = 0;

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int ferr0 = 0, ferr1 = 0, sends0 = 0, sends1 = 0, hold0 = 0, hold1 = 0;

  // Reference model of the angle registers.
  logic [7:0]  m0 [4];
  logic [11:0] m1 [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transmitter model + scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      hold0 = 0; hold1 = 0;
      tx_ready0 = 1'b1; tx_ready1 = 1'b1;
    end else begin
      if (frame_err0) ferr0++;
      if (frame_err1) ferr1++;
      if (tx_send0) begin
        sends0++;
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx0_unexpected actual=%0h expected=none", tx_data0);
        end else check("tx0_byte", tx_data0, exp0.pop_front());
        tx_ready0 = 1'b0; hold0 = 3;
      end else if (hold0 > 0) begin
        hold0--;
        if (hold0 == 0) tx_ready0 = 1'b1;
      end
      if (tx_send1) begin
        sends1++;
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx1_unexpected actual=%0h expected=none", tx_data1);
        end else check("tx1_byte", tx_data1, exp1.pop_front());
        tx_ready1 = 1'b0; hold1 = 3;
      end else if (hold1 > 0) begin
        hold1--;
        if (hold1 == 0) tx_ready1 = 1'b1;
      end
    end
  end

  // One byte strobed for one clock, followed by one idle clock.
  task automatic drive_byte(input int d, input logic [7:0] b);
    @(negedge clk);
    if (d == 0) begin rx_data0 = b; rx_valid0 = 1'b1; end
    else        begin rx_data1 = b; rx_valid1 = 1'b1; end
    @(negedge clk);
    rx_valid0 = 1'b0;
    rx_valid1 = 1'b0;
  endtask

  task automatic wait_idle(input int d, input string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!((d == 0) ? busy0 : busy1)) break;
    end
    check(name, (d == 0) ? busy0 : busy1, 1'b0);
  endtask

  function automatic logic [63:0] model_bus(input int d);
    if (d == 0) return {32'h0, m0[3], m0[2], m0[1], m0[0]};
    return {16'h0, m1[3], m1[2], m1[1], m1[0]};
  endfunction

  function automatic logic [63:0] dut_bus(input int d);
    if (d == 0) return {32'h0, angle0};
    return {16'h0, angle1};
  endfunction

  task automatic check_angles(input int d, input string name);
`ifdef CON3_SLEW_EN
    for (int i = 0; i < 20000 && dut_bus(d) !== model_bus(d); i++) @(negedge clk);
`endif
    check(name, dut_bus(d), model_bus(d));
  endtask

  typedef struct {
    int         d;      // which instance
    int         n;      // bytes in frame
    logic [7:0] b0, b1, b2;
    int         ne;     // expected response bytes
    logic [7:0] e0, e1;
    int         ferr;   // expected frame_err pulses
    int         wr_ch;  // channel written, -1 for none
    logic [15:0] wr_val;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  int f_before, s_before, hit, c_last, n_chg;
  logic [7:0] prev_a, cur_a;

  initial begin
    for (int k = 0; k < 4; k++) begin m0[k] = '0; m1[k] = '0; end

    //          d  n  b0     b1     b2     ne e0     e1     ferr ch  val
    vt[0]  = '{0, 2, 8'hA2, 8'h80, 8'h00, 1, 8'h06, 8'h00, 0,  2, 16'h080};
    vt[1]  = '{0, 1, 8'hAA, 8'h00, 8'h00, 1, 8'h80, 8'h00, 0, -1, 16'h000};
    vt[2]  = '{0, 1, 8'h55, 8'h00, 8'h00, 1, 8'h15, 8'h00, 1, -1, 16'h000};
    vt[3]  = '{0, 1, 8'hA5, 8'h00, 8'h00, 1, 8'h15, 8'h00, 1, -1, 16'h000};
    vt[4]  = '{0, 2, 8'hA3, 8'h7F, 8'h00, 1, 8'h06, 8'h00, 0,  3, 16'h07F};
    vt[5]  = '{0, 1, 8'hAB, 8'h00, 8'h00, 1, 8'h7F, 8'h00, 0, -1, 16'h000};
    vt[6]  = '{0, 1, 8'hA8, 8'h00, 8'h00, 1, 8'h00, 8'h00, 0, -1, 16'h000};
    vt[7]  = '{0, 2, 8'hAA, 8'h55, 8'h00, 1, 8'h80, 8'h00, 1, -1, 16'h000};
    vt[8]  = '{0, 1, 8'hB2, 8'h00, 8'h00, 1, 8'h15, 8'h00, 1, -1, 16'h000};
    vt[9]  = '{1, 3, 8'hA0, 8'hF3, 8'h45, 1, 8'h06, 8'h00, 0,  0, 16'h345};
    vt[10] = '{1, 1, 8'hA8, 8'h00, 8'h00, 2, 8'h03, 8'h45, 0, -1, 16'h000};
    vt[11] = '{1, 3, 8'hA1, 8'hFF, 8'hFF, 1, 8'h06, 8'h00, 0,  1, 16'hFFF};
    vt[12] = '{1, 1, 8'hA9, 8'h00, 8'h00, 2, 8'h0F, 8'hFF, 0, -1, 16'h000};
    vt[13] = '{1, 1, 8'hAE, 8'h00, 8'h00, 1, 8'h15, 8'h00, 1, -1, 16'h000};

    // Reset state.
    #12;
    check("rst_tx_data",   tx_data0, 8'h00);
    check("rst_tx_send",   tx_send0, 1'b0);
    check("rst_busy",      busy0, 1'b0);
    check("rst_frame_err", frame_err0, 1'b0);
    check("rst_angle0",    angle0, 32'h0);
    check("rst_angle1",    angle1, 48'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      f_before = (vt[i].d == 0) ? ferr0 : ferr1;
      if (vt[i].d == 0) begin
        exp0.push_back(vt[i].e0);
        if (vt[i].ne == 2) exp0.push_back(vt[i].e1);
      end else begin
        exp1.push_back(vt[i].e0);
        if (vt[i].ne == 2) exp1.push_back(vt[i].e1);
      end
      drive_byte(vt[i].d, vt[i].b0);
      if (vt[i].n >= 2) drive_byte(vt[i].d, vt[i].b1);
      if (vt[i].n >= 3) drive_byte(vt[i].d, vt[i].b2);
      wait_idle(vt[i].d, $sformatf("v%0d_idle", i));
      if (vt[i].wr_ch >= 0) begin
        if (vt[i].d == 0) m0[vt[i].wr_ch] = vt[i].wr_val[7:0];
        else              m1[vt[i].wr_ch] = vt[i].wr_val[11:0];
      end
      check_angles(vt[i].d, $sformatf("v%0d_angle", i));
      check($sformatf("v%0d_ferr", i), ((vt[i].d == 0) ? ferr0 : ferr1) - f_before, vt[i].ferr);
      check($sformatf("v%0d_resp_left", i), (vt[i].d == 0) ? exp0.size() : exp1.size(), 0);
    end

    // Timeout: header only, then silence.
    f_before = ferr0;
    s_before = sends0;
    hit = -1;
    @(negedge clk);
    rx_data0 = 8'hA1; rx_valid0 = 1'b1;
    @(posedge clk);
    #1 rx_valid0 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (frame_err0 && hit < 0) hit = i;
    end
    check("tmo_pulse_cycle", hit, 49);
    check("tmo_ferr_count", ferr0 - f_before, 1);
    check("tmo_busy", busy0, 1'b0);
    check("tmo_no_send", sends0 - s_before, 0);
    check_angles(0, "tmo_angle");
    f_before = ferr0;
    exp0.push_back(8'h06);
    drive_byte(0, 8'hA1);
    drive_byte(0, 8'h10);
    wait_idle(0, "tmo_retry_idle");
    m0[1] = 8'h10;
    check_angles(0, "tmo_retry_angle");
    check("tmo_retry_ferr", ferr0 - f_before, 0);
    check("tmo_retry_resp", exp0.size(), 0);

`ifndef CON3_SLEW_EN
    // Commit latency: data byte sampled at edge n, angle changes after n+1.
    exp0.push_back(8'h06);
    drive_byte(0, 8'hA1);
    @(negedge clk);
    rx_data0 = 8'h22; rx_valid0 = 1'b1;
    @(posedge clk);
    #1 rx_valid0 = 1'b0;
    check("lat_n_plus_1", angle0, model_bus(0));
    m0[1] = 8'h22;
    @(posedge clk);
    #1 check("lat_n_plus_2", angle0, model_bus(0));
    wait_idle(0, "lat_idle");
`endif

`ifdef CON3_SLEW_EN
    // Ramp ch0 0 -> 5, one step per 4 cycles.
    exp0.push_back(8'h06);
    drive_byte(0, 8'hA0);
    drive_byte(0, 8'h05);
    prev_a = angle0[7:0];
    c_last = -1;
    n_chg = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cur_a = angle0[7:0];
      if (cur_a != prev_a) begin
        check("slew_step", cur_a, prev_a + 8'd1);
        if (c_last >= 0) check("slew_period", c - c_last, 4);
        c_last = c;
        prev_a = cur_a;
        n_chg++;
      end
    end
    check("slew_steps", n_chg, 5);
    check("slew_final", angle0[7:0], 8'h05);
    // Ramp back down, reset part way.
    exp0.push_back(8'h06);
    drive_byte(0, 8'hA0);
    drive_byte(0, 8'h00);
    repeat (9) @(negedge clk);
    check("slew_mid_ramp", (angle0[7:0] > 8'd0) && (angle0[7:0] < 8'd5), 1'b1);
    #2 rst = 1'b1;
    #1;
    check("slew_rst_angle0", angle0, 32'h0);
    check("slew_rst_angle1", angle1, 48'h0);
    check("slew_rst_busy", busy0, 1'b0);
    check("slew_rst_tx_send", tx_send0, 1'b0);
    check("slew_rst_tx_data", tx_data0, 8'h00);
    exp0.delete();
    exp1.delete();
    s_before = sends0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("slew_rst_no_send", sends0 - s_before, 0);
    check("slew_rst_hold", angle0, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/con3_servo_ctrl.md
Name: con3_servo_ctrl

Overview:
- Byte-protocol command parser sitting between a UART transceiver (receive strobe / transmit handshake) and a Pmod CON3 servo driver.
- Decodes framed write/read commands and holds a separate angle register per servo channel.
- Parametrised in channel count and angle width.
- Answers every frame with ACK, NAK or readback bytes over the UART transmit path.

Parameters:
CHANNELS, 4, number of servo channels (1..8)
ANGLE_W, 8, angle register width in bits (1..16); NB = ceil(ANGLE_W/8) data bytes per value
TIMEOUT_CYC, 1000000, max clk cycles between bytes of one frame before discard
SLEW_DIV, 100000, clk cycles per 1-LSB angle step (used only with CON3_SLEW_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_data  in  8  received byte, valid when rx_valid=1
rx_valid  in  1  one-cycle strobe per received byte
tx_ready  in  1  transmitter idle
tx_data  out  8  byte to transmit, stable while sending
tx_send  out  1  one-cycle transmit request
angle  out  CHANNELS*ANGLE_W  channel k at bits [k*ANGLE_W +: ANGLE_W]
busy  out  1  frame in progress or response pending
frame_err  out  1  one-cycle pulse on any protocol error

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset all angle/target registers = 0, tx_data=0, tx_send=0, busy=0, frame_err=0, state=IDLE, timeout counter=0.
- Reset mid-frame or mid-response discards everything; no byte is sent.
- Header byte: [7:4] must be 4'hA; [3] = op (0 write, 1 read); [2:0] = channel.
- Write frame: header followed by NB data bytes, MSB first. The value is the low ANGLE_W bits of the assembled word; excess upper bits are ignored.
- Read frame: header only.
- States: IDLE, DATA, COMMIT, RESP, WAIT_TX.
- IDLE, on rx_valid:
  - Sync nibble wrong or channel >= CHANNELS -> frame_err pulse next cycle, queue NAK 0x15 -> RESP.
  - Valid write -> DATA, byte count = 0.
  - Valid read -> RESP, queue NB bytes of the channel's target, MSB first, upper pad bits 0.
- DATA: each rx_valid shifts the byte in. After the NB-th byte -> COMMIT.
- COMMIT (one cycle): writes the target register, queues ACK 0x06 -> RESP.
- Latency: last data byte's rx_valid at cycle n -> angle output updated at n+2 (without slew).
- Timeout: counter resets on every rx_valid and counts only in DATA. On reaching TIMEOUT_CYC-1: frame_err pulse, return to IDLE, no response, registers unchanged.
- RESP: when tx_ready=1, drive tx_data and pulse tx_send for one cycle -> WAIT_TX.
- WAIT_TX: waits for tx_ready to go low, then high again. The transmitter must drop tx_ready within 2 cycles of tx_send. Then send the next queued byte (-> RESP) or return to IDLE.
- rx_valid while in COMMIT/RESP/WAIT_TX: byte dropped, frame_err pulse (overrun), response continues unaffected.
- busy = 1 in every state except IDLE.
- Response queue depth = max(NB,1) bytes.

Optional Feature:
Macro CON3_SLEW_EN.
- Defined:
  - Each channel keeps target and current registers; angle outputs the current register.
  - A shared prescaler counts 0..SLEW_DIV-1. On wrap, each channel whose current != target steps by 1 toward target.
  - Readback returns target.
  - A write during an in-progress ramp retargets from the present current value.
- Undefined: no current register; angle = target immediately on COMMIT.

Test Plan:
- CHANNELS=4, ANGLE_W=8: rx 0xA2, 0x80 -> angle[23:16]=0x80 two cycles after second rx_valid, other channels 0; one tx_send with tx_data=0x06.
- After the above, rx 0xAA -> single tx_send with tx_data=0x80; angle unchanged.
- rx 0x55, then separately 0xA5 -> each: frame_err pulse, tx_data=0x15; no angle change.
- TIMEOUT_CYC=50: rx 0xA1, then idle 60 cycles -> frame_err pulse at cycle 49 after the header, busy=0, no tx_send. Then rx 0xA1, 0x10 -> angle[15:8]=0x10 and ACK 0x06.
- ANGLE_W=12: rx 0xA0, 0xF3, 0x45 -> angle[11:0]=0x345. Read 0xA8 -> tx bytes 0x03, 0x45 in order.
- CON3_SLEW_EN, SLEW_DIV=4: write ch0=0x05 from 0 -> angle[7:0] increments every 4 cycles, reaches 0x05 after 5 steps and holds. Assert rst mid-ramp -> all outputs 0 immediately.
